alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//   Upstream feeder for the alu. Accepts one ALU instruction per cycle, reads operands from an
//   internal 8x8 register file (or an immediate), and registers a/b/op onto the alu inputs.
//   One cycle later it captures the alu result and flags, writing back to the register file
//   and to a 5-bit flags register.
//   Two-stage pipeline (OF -> EX/WB) with one-deep forwarding and a global stall.
// PARAMETERS
//   DATA_W   8  operand/result width; must match the alu
//   NREGS    8  register count; REG_AW = $clog2(NREGS) = 3
//   FLAGS_W  5  flags register width {parity,overflow,carry,negative,zero}
// PORTS
//   clk        in   1        single clock; all state updates on posedge
//   rst        in   1        synchronous, active-high reset
//   in_valid   in   1        instruction present
//   in_ready   out  1        = ~stall; accept when in_valid & in_ready
//   in_op      in   4        alu opcode (`OP_* from constants.v)
//   in_rd      in   REG_AW   destination register
//   in_rs_a    in   REG_AW   source A register
//   in_rs_b    in   REG_AW   source B register (ignored if in_use_imm)
//   in_imm     in   DATA_W   immediate for B
//   in_use_imm in   1        1: B = in_imm
//   in_wb      in   1        write result to rd
//   in_setf    in   1        update flags register
//   stall      in   1        freeze both stages
//   alu_a      out  DATA_W   registered alu operand A
//   alu_b      out  DATA_W   registered alu operand B
//   alu_op     out  4        registered alu opcode
//   alu_out    in   DATA_W   alu result (combinational from alu_a/b/op)
//   alu_flags  in   FLAGS_W  {parity,overflow,carry,negative,zero} from the alu
//   ex_valid   out  1        EX stage holds a live instruction
//   flags      out  FLAGS_W  architectural flags register
//   dbg_addr   in   REG_AW   debug read address
//   dbg_data   out  DATA_W   combinational register-file read of dbg_addr
// BEHAVIOUR
//   Reset (rst=1 at posedge, overrides everything):
//     - all registers <= 0; flags <= 0; ex_valid <= 0
//     - alu_a = alu_b = 0; alu_op <= `OP_SUM
//     - in-flight EX instruction is discarded with no writeback
//   OF (cycle t, accepted):
//     - opA = regfile[rs_a]; opB = use_imm ? imm : regfile[rs_b]
//     - forwarding: if ex_valid & ex_wb & ex_rd == rs_x, substitute alu_out (only for B when !use_imm)
//     - at posedge: alu_a/b/op and ex_rd/ex_wb/ex_setf <= values; ex_valid <= 1
//   No accept (in_valid=0, stall=0): ex_valid <= 0; alu_a/b/op hold their last values.
//   EX/WB (cycle t+1):
//     - alu computes combinationally
//     - at posedge, if ex_valid & !stall: wb -> regfile[ex_rd] <= alu_out; setf -> flags <= alu_flags
//     - result visible on dbg_data from cycle t+2 (latency 2)
//   Stall=1: no accept; EX regs, alu_a/b/op, regfile and flags all hold. EX writes back on the
//     first non-stall edge; forwarding stays valid across the stall.
//   Back-to-back dependency (I2 reads I1.rd the cycle after I1): served by forwarding, no bubble.
//     Distance >= 2 reads the register file.
//   rs_a == rs_b == in-flight rd: both operands are forwarded.
//   wb=0 & setf=1 (compare): flags update only. wb=0 & setf=0: no architectural effect.
//   No register is hardwired to zero.
// STRUCTURE
//   constants.v: `OP_* opcodes; flag bit indices `FLAG_Z=0, `FLAG_N=1, `FLAG_C=2, `FLAG_V=3, `FLAG_P=4
//   Sub-module reg_file:
//     - NREGS x DATA_W, two async read ports + one debug read, one sync write port
//     - synchronous reset clears all entries
//   Forwarding mux and pipeline registers live in alu_issue_stage. Bench instantiates the real alu.
// TESTING
//   1. Reset, then read r0..r7 via dbg -> all 0; flags = 0; ex_valid = 0; alu_op = `OP_SUM.
//   2. r1 = 0 + imm 5 (OP_SUM, use_imm, wb) then r2 = r1 + imm 10 next cycle
//      -> r2 = 15 via forwarding, no bubble.
//   3. r3 = imm 200 + imm 100 chain (r3 = 200, then r3 = r3 + 100, setf)
//      -> r3 = 44, carry = 1, zero = 0.
//   4. setf SUM r4 = r0 + r0 with r0 = 0 -> zero = 1, parity per alu; r4 = 0.
//      Follow with wb=0, setf=0 -> flags unchanged.
//   5. Issue r5 = imm 7; assert stall for 3 cycles at EX:
//      -> r5 stays 0 during stall, in_ready = 0, becomes 7 one edge after release.
//   6. Issue r6 = imm 9, assert rst during EX -> r6 = 0, ex_valid = 0 next cycle.

Source files
------------

// File: rtl/alu_issue_stage_pkg.sv
// alu_issue_stage_pkg
//   Shared widths, ALU opcode encoding, flag bit positions and the EX-stage
//   control bundle used by the issue stage and its register file.
package alu_issue_stage_pkg;

  localparam int DATA_W  = 8;
  localparam int NREGS   = 8;
  localparam int REG_AW  = $clog2(NREGS);
  localparam int FLAGS_W = 5;
  localparam int OP_W    = 4;

  typedef enum logic [OP_W-1:0] {
    OP_SUM = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7
  } alu_op_e;

  // Flag vector layout {parity, overflow, carry, negative, zero}
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;
  localparam int FLAG_P = 4;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              wb;
    logic              setf;
  } ex_ctrl_t;

endpackage

// File: rtl/alu_issue_stage_reg_file.sv
// alu_issue_stage_reg_file
//   NREGS x DATA_W register file: two asynchronous operand read ports, one
//   asynchronous debug read port, one synchronous write port. Synchronous
//   active-high reset clears every entry and takes priority over a write.
// Ports
//   i_clk, i_rst            clock, synchronous reset
//   i_we/i_waddr/i_wdata    write port
//   i_raddr_a/o_rdata_a     operand A read
//   i_raddr_b/o_rdata_b     operand B read
//   i_dbg_addr/o_dbg_data   debug read
module alu_issue_stage_reg_file
  import alu_issue_stage_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr_a,
  input  logic [REG_AW-1:0] i_raddr_b,
  input  logic [REG_AW-1:0] i_dbg_addr,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b,
  output logic [DATA_W-1:0] o_dbg_data
);

  logic [DATA_W-1:0] r_mem [NREGS];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a  = r_mem[i_raddr_a];
  assign o_rdata_b  = r_mem[i_raddr_b];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Two-stage feeder for an external combinational ALU. OF reads operands
//   from the register file (or immediate), with one-deep forwarding from the
//   EX result, and registers them onto the ALU inputs. EX/WB captures the
//   ALU result into the register file and the ALU flags into the flags
//   register. A global stall freezes both stages.
// Ports
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_in_valid / o_in_ready           instruction handshake (ready = ~stall)
//   i_in_op, i_in_rd, i_in_rs_a/b     opcode, destination, sources
//   i_in_imm, i_in_use_imm            immediate operand for B
//   i_in_wb, i_in_setf                write rd / update flags
//   i_stall                           freeze both stages
//   o_alu_a, o_alu_b, o_alu_op        registered ALU inputs
//   i_alu_out, i_alu_flags            ALU result and flags
//   o_ex_valid                        EX holds a live instruction
//   o_flags                           architectural flags register
//   i_dbg_addr / o_dbg_data           debug register-file read
module alu_issue_stage
  import alu_issue_stage_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [OP_W-1:0]    i_in_op,
  input  logic [REG_AW-1:0]  i_in_rd,
  input  logic [REG_AW-1:0]  i_in_rs_a,
  input  logic [REG_AW-1:0]  i_in_rs_b,
  input  logic [DATA_W-1:0]  i_in_imm,
  input  logic               i_in_use_imm,
  input  logic               i_in_wb,
  input  logic               i_in_setf,
  input  logic               i_stall,
  output logic [DATA_W-1:0]  o_alu_a,
  output logic [DATA_W-1:0]  o_alu_b,
  output logic [OP_W-1:0]    o_alu_op,
  input  logic [DATA_W-1:0]  i_alu_out,
  input  logic [FLAGS_W-1:0] i_alu_flags,
  output logic               o_ex_valid,
  output logic [FLAGS_W-1:0] o_flags,
  input  logic [REG_AW-1:0]  i_dbg_addr,
  output logic [DATA_W-1:0]  o_dbg_data
);

  logic [DATA_W-1:0]  r_alu_a;
  logic [DATA_W-1:0]  r_alu_b;
  logic [OP_W-1:0]    r_alu_op;
  logic               r_ex_valid;
  ex_ctrl_t           r_ex;
  logic [FLAGS_W-1:0] r_flags;

  logic               w_accept;
  logic               w_rf_we;
  logic               w_fwd_a;
  logic               w_fwd_b;
  logic [DATA_W-1:0]  w_rf_a;
  logic [DATA_W-1:0]  w_rf_b;
  logic [DATA_W-1:0]  w_op_a;
  logic [DATA_W-1:0]  w_op_b;

  assign w_accept = i_in_valid & ~i_stall;

  // Writeback waits for the first non-stalled edge; the ALU inputs are held
  // meanwhile so i_alu_out stays the same result throughout the stall.
  assign w_rf_we  = r_ex_valid & r_ex.wb & ~i_stall;

  alu_issue_stage_reg_file u_reg_file (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_we       (w_rf_we),
    .i_waddr    (r_ex.rd),
    .i_wdata    (i_alu_out),
    .i_raddr_a  (i_in_rs_a),
    .i_raddr_b  (i_in_rs_b),
    .i_dbg_addr (i_dbg_addr),
    .o_rdata_a  (w_rf_a),
    .o_rdata_b  (w_rf_b),
    .o_dbg_data (o_dbg_data)
  );

  // The EX result has not reached the register file yet, so a matching
  // source takes the live ALU output instead.
  assign w_fwd_a = r_ex_valid & r_ex.wb & (r_ex.rd == i_in_rs_a);
  assign w_fwd_b = r_ex_valid & r_ex.wb & (r_ex.rd == i_in_rs_b) & ~i_in_use_imm;

  assign w_op_a = w_fwd_a ? i_alu_out : w_rf_a;
  assign w_op_b = i_in_use_imm ? i_in_imm :
                  (w_fwd_b ? i_alu_out : w_rf_b);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= OP_SUM;
      r_ex_valid <= 1'b0;
      r_ex       <= '0;
      r_flags    <= '0;
    end else if (!i_stall) begin
      if (r_ex_valid && r_ex.setf) begin
        r_flags <= i_alu_flags;
      end
      if (w_accept) begin
        r_alu_a    <= w_op_a;
        r_alu_b    <= w_op_b;
        r_alu_op   <= i_in_op;
        r_ex.rd    <= i_in_rd;
        r_ex.wb    <= i_in_wb;
        r_ex.setf  <= i_in_setf;
        r_ex_valid <= 1'b1;
      end else begin
        r_ex_valid <= 1'b0;
      end
    end
  end

  assign o_in_ready = ~i_stall;
  assign o_alu_a    = r_alu_a;
  assign o_alu_b    = r_alu_b;
  assign o_alu_op   = r_alu_op;
  assign o_ex_valid = r_ex_valid;
  assign o_flags    = r_flags;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [2:0]  in_rd, in_rs_a, in_rs_b;
  logic [7:0]  in_imm;
  logic        in_use_imm, in_wb, in_setf, stall;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [7:0]  alu_out;
  logic [4:0]  alu_flags;
  logic        ex_valid;
  logic [4:0]  flags;
  logic [2:0]  dbg_addr;
  logic [7:0]  dbg_data;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .i_clk(clk), .i_rst(rst),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_op(in_op), .i_in_rd(in_rd), .i_in_rs_a(in_rs_a), .i_in_rs_b(in_rs_b),
    .i_in_imm(in_imm), .i_in_use_imm(in_use_imm), .i_in_wb(in_wb), .i_in_setf(in_setf),
    .i_stall(stall),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
    .i_alu_out(alu_out), .i_alu_flags(alu_flags),
    .o_ex_valid(ex_valid), .o_flags(flags),
    .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_data)
  );

  // ALU behaviour: returns {parity, overflow, carry, negative, zero, result}
  function automatic logic [12:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_SUM: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      OP_SUB: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a;
      OP_SHL: begin r = a << 1; c = a[7]; end
      OP_SHR: begin r = a >> 1; c = a[0]; end
      default: r = b;
    endcase
    return {^r, v, c, r[7], (r == 8'd0), r};
  endfunction

  always_comb begin
    {alu_flags, alu_out} = alu_f(alu_op, alu_a, alu_b);
  end

  // Program-order model: m_arch is the value any newly issued instruction must
  // see, m_vis is what the register file must show after writeback.
  logic [7:0] m_arch [8];
  logic [7:0] m_vis  [8];
  logic [4:0] m_flags;
  logic       m_live = 1'b0;
  logic       m_pend;
  logic [2:0] m_rd;
  logic       m_wb, m_setf;
  logic [7:0] m_res;
  logic [4:0] m_rflags;
  logic [7:0] m_a, m_b;
  logic [3:0] m_op;

  always @(posedge clk) begin
    logic [7:0]  a, b;
    logic [12:0] fr;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin m_arch[i] = 8'd0; m_vis[i] = 8'd0; end
      m_flags = 5'd0; m_pend = 1'b0; m_rd = 3'd0; m_wb = 1'b0; m_setf = 1'b0;
      m_res = 8'd0; m_rflags = 5'd0; m_a = 8'd0; m_b = 8'd0; m_op = OP_SUM;
      m_live = 1'b1;
    end else if (!stall) begin
      if (m_pend) begin
        if (m_wb)   m_vis[m_rd] = m_res;
        if (m_setf) m_flags = m_rflags;
      end
      if (in_valid) begin
        a  = m_arch[in_rs_a];
        b  = in_use_imm ? in_imm : m_arch[in_rs_b];
        fr = alu_f(in_op, a, b);
        if (in_wb) m_arch[in_rd] = fr[7:0];
        m_a = a; m_b = b; m_op = in_op;
        m_rd = in_rd; m_wb = in_wb; m_setf = in_setf;
        m_res = fr[7:0]; m_rflags = fr[12:8];
        m_pend = 1'b1;
      end else begin
        m_pend = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_pend});
      chk("alu_a",    {24'd0, alu_a},    {24'd0, m_a});
      chk("alu_b",    {24'd0, alu_b},    {24'd0, m_b});
      chk("alu_op",   {28'd0, alu_op},   {28'd0, m_op});
      chk("flags",    {27'd0, flags},    {27'd0, m_flags});
      chk("in_ready", {31'd0, in_ready}, {31'd0, ~stall});
      chk("dbg_data", {24'd0, dbg_data}, {24'd0, m_vis[dbg_addr]});
    end
  end

  task automatic peek(input logic [2:0] a, input logic [7:0] exp, input string nm);
    dbg_addr = a;
    #1;
    chk(nm, {24'd0, dbg_data}, {24'd0, exp});
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                       input logic [2:0] rb, input logic [7:0] imm, input logic use_imm,
                       input logic wb, input logic setf);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs_a = ra; in_rs_b = rb;
    in_imm = imm; in_use_imm = use_imm; in_wb = wb; in_setf = setf;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs_a = '0; in_rs_b = '0;
    in_imm = '0; in_use_imm = 1'b0; in_wb = 1'b0; in_setf = 1'b0; stall = 1'b0; dbg_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // reset state
    for (int i = 0; i < 8; i++) peek(i[2:0], 8'd0, "reset_reg");
    chk("reset_flags",    {27'd0, flags},    32'd0);
    chk("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset_alu_op",   {28'd0, alu_op},   32'd0);

    // back-to-back forwarding: r1 = 5, r2 = r1 + 10
    issue(OP_SUM, 3'd1, 3'd0, 3'd0, 8'd5,  1'b1, 1'b1, 1'b0);
    issue(OP_SUM, 3'd2, 3'd1, 3'd0, 8'd10, 1'b1, 1'b1, 1'b0);
    chk("fwd_alu_a", {24'd0, alu_a}, 32'd5);
    chk("fwd_alu_b", {24'd0, alu_b}, 32'd10);
    idle(2);
    peek(3'd1, 8'd5,  "r1_fwd");
    peek(3'd2, 8'd15, "r2_fwd");

    // carry chain: r3 = 200; r3 = r3 + 100 with flags
    issue(OP_SUM, 3'd3, 3'd0, 3'd0, 8'd200, 1'b1, 1'b1, 1'b0);
    issue(OP_SUM, 3'd3, 3'd3, 3'd0, 8'd100, 1'b1, 1'b1, 1'b1);
    idle(2);
    peek(3'd3, 8'd44, "r3_carry");
    chk("carry_flag", {31'd0, flags[FLAG_C]}, 32'd1);
    chk("zero_flag",  {31'd0, flags[FLAG_Z]}, 32'd0);
    chk("flags_300",  {27'd0, flags}, 32'h14);

    // zero result with flags, then a no-effect instruction
    issue(OP_SUM, 3'd4, 3'd0, 3'd0, 8'd0, 1'b0, 1'b1, 1'b1);
    issue(OP_SUB, 3'd5, 3'd0, 3'd0, 8'd1, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk("flags_zero", {27'd0, flags}, 32'h01);
    peek(3'd4, 8'd0, "r4_zero");
    peek(3'd5, 8'd0, "r5_noeffect");

    // both sources forwarded, then distance-2 register-file read
    issue(OP_SUM, 3'd1, 3'd0, 3'd0, 8'd3,   1'b1, 1'b1, 1'b0);
    issue(OP_SUM, 3'd6, 3'd1, 3'd1, 8'd0,   1'b0, 1'b1, 1'b0);
    issue(OP_XOR, 3'd4, 3'd3, 3'd0, 8'hFF,  1'b1, 1'b1, 1'b0);
    idle(2);
    peek(3'd6, 8'd6,   "r6_dual_fwd");
    peek(3'd4, 8'hD3,  "r4_xor");

    // stall with r5 = 7 in EX; an offered instruction must not be taken
    issue(OP_SUM, 3'd5, 3'd0, 3'd0, 8'd7, 1'b1, 1'b1, 1'b0);
    stall = 1'b1;
    in_valid = 1'b1; in_op = OP_SUM; in_rd = 3'd7; in_rs_a = 3'd0; in_imm = 8'd33;
    in_use_imm = 1'b1; in_wb = 1'b1; in_setf = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      peek(3'd5, 8'd0, "r5_stalled");
      chk("ready_stalled", {31'd0, in_ready}, 32'd0);
      chk("ex_held",       {31'd0, ex_valid}, 32'd1);
    end
    stall = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    peek(3'd5, 8'd7, "r5_released");
    peek(3'd7, 8'd0, "r7_not_taken");

    // reset while r6 = 9 is in EX
    issue(OP_SUM, 3'd6, 3'd0, 3'd0, 8'd9, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    peek(3'd6, 8'd0, "r6_reset");
    chk("ex_valid_rst", {31'd0, ex_valid}, 32'd0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
